// File: rtl/muldiv_unit.sv
// Purpose : iterative mult/multu/div/divu sequencer that owns the HI/LO pair.
// Latency : 33 cycles from the start edge to hi/lo update and the done pulse.
// Backpressure: start is ignored while busy; no queuing; cancel aborts in flight.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start, op          launch request and opcode (00 mult, 01 multu, 10 div, 11 divu)
//   din1, din2         rs / rt operands, latched on the start edge
//   cancel             pipeline flush: aborts the running op, blocks start in IDLE
//   hiWe, loWe, wdata  mthi / mtlo writes, honoured only in IDLE
//   busy               high whenever the sequencer is not IDLE (combinational)
//   done               one-cycle pulse after the FIX edge
//   hi, lo             architectural HI / LO registers
module muldiv_unit (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] din1,
   input  logic [31:0] din2,
   input  logic        cancel,
   input  logic        hiWe,
   input  logic        loWe,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic        is_div;
   logic        neg_q;     // product / quotient must be negated in FIX
   logic        neg_r;     // remainder takes the (negative) dividend sign
   logic        dz;        // divide by zero: run the sequence, discard result
   logic [31:0] opnd;      // multiplicand magnitude or divisor magnitude
   logic [63:0] acc;       // mult: {partial product, multiplier}; div: [31:0] dividend/quotient
   logic [31:0] rem;       // divide partial remainder (always < divisor)

   // operand magnitudes; -0x8000_0000 wraps to itself, which is the correct magnitude
   logic        sgn, a_neg, b_neg;
   logic [31:0] mag1, mag2;

   // one iteration of each algorithm
   logic [32:0] msum;
   logic [63:0] mul_nxt;
   logic [32:0] dshift, diff;
   logic        div_ok;

   // FIX-stage sign correction
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix, res_hi, res_lo;

   logic        load, step, write_res;

   always_comb begin
      sgn   = ~op[0];
      a_neg = sgn & din1[31];
      b_neg = sgn & din2[31];
      mag1  = a_neg ? (32'd0 - din1) : din1;
      mag2  = b_neg ? (32'd0 - din2) : din2;
   end

   always_comb begin
      // shift-add: add multiplicand into the upper half when the next
      // multiplier bit is set, then shift the whole register right
      msum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
      mul_nxt = {msum, acc[31:1]};

      // restoring step. Because rem < divisor, the shifted value is below
      // twice the divisor, so bit 32 of the 33-bit difference is exactly the
      // borrow: clear means the trial subtraction succeeds.
      dshift  = {rem, acc[31]};
      diff    = dshift - {1'b0, opnd};
      div_ok  = ~diff[32];
   end

   always_comb begin
      prod_fix = neg_q ? (64'd0 - acc) : acc;
      quo_fix  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
      rem_fix  = neg_r ? (32'd0 - rem) : rem;
      res_hi   = is_div ? rem_fix : prod_fix[63:32];
      res_lo   = is_div ? quo_fix : prod_fix[31:0];
   end

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state and control strobes
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      write_res = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start && !cancel) begin
               load      = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (cancel) begin
               state_nxt = IDLE;
            end else begin
               step = 1'b1;
               if (cnt == 5'd31) state_nxt = FIX;
            end
         end
         FIX: begin
            state_nxt = IDLE;
            write_res = !cancel && !dz;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // datapath
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt    <= 5'd0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         opnd   <= 32'd0;
         acc    <= 64'd0;
         rem    <= 32'd0;
      end else if (load) begin
         cnt    <= 5'd0;
         is_div <= op[1];
         neg_q  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         dz     <= op[1] && (din2 == 32'd0);
         opnd   <= op[1] ? mag2 : mag1;
         acc    <= {32'd0, (op[1] ? mag1 : mag2)};
         rem    <= 32'd0;
      end else if (step) begin
         cnt <= cnt + 5'd1;
         if (is_div) begin
            acc[31:0] <= {acc[30:0], div_ok};
            rem       <= div_ok ? diff[31:0] : dshift[31:0];
         end else begin
            acc <= mul_nxt;
         end
      end
   end

   // HI/LO and done. An mthi/mtlo in the start cycle lands first and is
   // later overwritten by the result.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hi   <= 32'd0;
         lo   <= 32'd0;
         done <= 1'b0;
      end else begin
         done <= (state == FIX) && !cancel;
         if (write_res) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state == IDLE) begin
            if (hiWe) hi <= wdata;
            if (loWe) lo <= wdata;
         end
      end
   end

endmodule
